cpu7_ifu_imem_resp: RTL and testbench

//  Responder end of the IFU instruction-fetch interface. Accepts inst_req/inst_addr

---
 rtl/cpu7_ifu_imem_resp.sv | 150 +++++++++++++++
 tb/tb_cpu7_ifu_imem_resp.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu7_ifu_imem_resp.sv
// Instruction-fetch responder: accepts IFU fetch requests, drives a
// synchronous-read instruction SRAM and returns one instruction per request
// with address-exception and uncache attributes. A cancel kills whatever is
// in flight; a request presented in the cancel cycle becomes the new target.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  S_IDLE | no request in flight, ready to accept
//  S_WAIT | request latched, burning WAIT_CYC cycles before the SRAM read
//  S_RESP | SRAM data (or exception) returned this cycle
module cpu7_ifu_imem_resp #(
    parameter int          ADDR_W   = 14,
    parameter logic [31:0] RAM_BASE = 32'h1c00_0000,
    parameter logic [31:0] UNC_BASE = 32'h1f00_0000,
    parameter logic [31:0] UNC_MASK = 32'hff00_0000,
    parameter int          WAIT_CYC = 0,
    parameter int          GRLEN    = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [31:0]       inst_addr,
    input  logic              inst_cancel,
    output logic              inst_addr_ok,
    output logic              inst_valid_f,
    output logic [GRLEN-1:0]  inst_rdata_f,
    output logic [1:0]        inst_count,
    output logic              inst_ex,
    output logic [5:0]        inst_exccode,
    output logic              inst_uncache,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_rdata
);

    localparam int CNT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
    localparam bit PIPE  = (WAIT_CYC == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               pend_ex, pend_unc;
    logic [ADDR_W-1:0]  pend_idx;
    logic [31:0]        hold_rdata;
    logic               hold_ex, hold_unc;

    logic [31:0]        off;
    logic               req_ex, req_unc;
    logic [ADDR_W-1:0]  req_idx;
    logic               accept, resp_valid;
    logic               ram_en_c;
    logic [ADDR_W-1:0]  ram_addr_c;
    logic [31:0]        resp_rdata, rdata32;

    // Request decode: window offset, exception and uncache attributes.
    always_comb begin
        off     = inst_addr - RAM_BASE;
        req_ex  = (inst_addr[1:0] != 2'b00) || ((off >> (ADDR_W + 2)) != 32'd0);
        req_unc = ((inst_addr & UNC_MASK) == (UNC_BASE & UNC_MASK));
        req_idx = off[ADDR_W+1:2];
        // Back-to-back accept from S_RESP only when there is no wait phase.
        accept  = inst_req && resetn &&
                  ((state == S_IDLE) || inst_cancel || (PIPE && (state == S_RESP)));
        resp_valid = resetn && (state == S_RESP) && !inst_cancel;
    end

    // Next state, wait counter and SRAM read strobe.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ram_en_c   = 1'b0;
        ram_addr_c = pend_idx;
        case (state)
            S_WAIT: begin
                if (cnt <= CNT_W'(1)) begin
                    ram_en_c  = !pend_ex;
                    state_nxt = S_RESP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = state;
        endcase
        if (inst_cancel) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            ram_en_c  = 1'b0;
        end
        if (accept) begin
            if (PIPE) begin
                ram_en_c   = !req_ex;
                ram_addr_c = req_idx;
                state_nxt  = S_RESP;
            end else begin
                state_nxt = S_WAIT;
                cnt_nxt   = CNT_W'(WAIT_CYC);
            end
        end
    end

    // State, latched request attributes and held response fields.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pend_ex    <= 1'b0;
            pend_unc   <= 1'b0;
            pend_idx   <= '0;
            hold_rdata <= '0;
            hold_ex    <= 1'b0;
            hold_unc   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                pend_ex  <= req_ex;
                pend_unc <= req_unc;
                pend_idx <= req_idx;
            end
            if (resp_valid) begin
                hold_rdata <= resp_rdata;
                hold_ex    <= pend_ex;
                hold_unc   <= pend_unc;
            end
        end
    end

    // Response outputs: live in the response cycle, otherwise the last value.
    always_comb begin
        resp_rdata   = pend_ex ? 32'd0 : ram_rdata;
        rdata32      = resp_valid ? resp_rdata : hold_rdata;
        inst_addr_ok = accept;
        inst_valid_f = resp_valid;
        inst_rdata_f = GRLEN'(rdata32);
        inst_count   = resp_valid ? 2'd1 : 2'd0;
        inst_ex      = resp_valid ? pend_ex : hold_ex;
        inst_exccode = inst_ex ? 6'h08 : 6'h00;
        inst_uncache = resp_valid ? pend_unc : hold_unc;
        ram_en       = ram_en_c && resetn;
        ram_addr     = resetn ? ram_addr_c : '0;
    end

endmodule

// File: tb/tb_cpu7_ifu_imem_resp.sv
// Bench for cpu7_ifu_imem_resp: a pipelined instance (WAIT_CYC=0) checked
// through a response scoreboard, and a WAIT_CYC=2 instance checked by
// cycle-exact directed sequences including an asynchronous reset mid-wait.
module tb_cpu7_ifu_imem_resp;

    localparam int          ADDR_W = 14;
    localparam logic [31:0] BASE   = 32'h1c00_0000;
    localparam int          GRLEN  = 64;

    typedef struct {
        logic [31:0] rdata;
        logic        ex;
        logic        unc;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // dut0 signals (WAIT_CYC=0)
    logic              rst0 = 1'b0, req0 = 1'b0, cancel0 = 1'b0;
    logic [31:0]       addr0 = '0;
    logic              ok0, valid0, ex0, unc0, ram_en0;
    logic [GRLEN-1:0]  rdata0;
    logic [1:0]        count0;
    logic [5:0]        exc0;
    logic [ADDR_W-1:0] ram_addr0;
    logic [31:0]       ram_rdata0 = '0;

    // dut2 signals (WAIT_CYC=2)
    logic              rst2 = 1'b0, req2 = 1'b0, cancel2 = 1'b0;
    logic [31:0]       addr2 = '0;
    logic              ok2, valid2, ex2, unc2, ram_en2;
    logic [GRLEN-1:0]  rdata2;
    logic [1:0]        count2;
    logic [5:0]        exc2;
    logic [ADDR_W-1:0] ram_addr2;
    logic [31:0]       ram_rdata2 = '0;

    cpu7_ifu_imem_resp #(.WAIT_CYC(0), .GRLEN(GRLEN)) dut0 (
        .clk(clk), .resetn(rst0), .inst_req(req0), .inst_addr(addr0),
        .inst_cancel(cancel0), .inst_addr_ok(ok0), .inst_valid_f(valid0),
        .inst_rdata_f(rdata0), .inst_count(count0), .inst_ex(ex0),
        .inst_exccode(exc0), .inst_uncache(unc0), .ram_en(ram_en0),
        .ram_addr(ram_addr0), .ram_rdata(ram_rdata0)
    );

    cpu7_ifu_imem_resp #(.WAIT_CYC(2), .GRLEN(GRLEN)) dut2 (
        .clk(clk), .resetn(rst2), .inst_req(req2), .inst_addr(addr2),
        .inst_cancel(cancel2), .inst_addr_ok(ok2), .inst_valid_f(valid2),
        .inst_rdata_f(rdata2), .inst_count(count2), .inst_ex(ex2),
        .inst_exccode(exc2), .inst_uncache(unc2), .ram_en(ram_en2),
        .ram_addr(ram_addr2), .ram_rdata(ram_rdata2)
    );

    function automatic logic [31:0] ram_fn(input logic [ADDR_W-1:0] i);
        return 32'h9E37_79B9 * {18'd0, i} + 32'h1357_9BDF;
    endfunction

    // Synchronous-read SRAM models
    always @(posedge clk) if (ram_en0) ram_rdata0 <= ram_fn(ram_addr0);
    always @(posedge clk) if (ram_en2) ram_rdata2 <= ram_fn(ram_addr2);

    function automatic resp_t exp_of(input logic [31:0] a);
        resp_t       r;
        logic [31:0] o;
        o       = a - BASE;
        r.ex    = (a[1:0] != 2'b00) || (o >= 32'h0001_0000);
        r.unc   = ((a & 32'hff00_0000) == 32'h1f00_0000);
        r.rdata = r.ex ? 32'd0 : ram_fn(o[15:2]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- dut0 scoreboard ----------------
    resp_t q0[$];
    resp_t last0 = '{rdata: 32'd0, ex: 1'b0, unc: 1'b0};

    always @(negedge clk) begin
        if (rst0) begin
            if (valid0) begin
                if (q0.size() == 0) begin
                    check("unexpected_valid0", 1, 0);
                end else begin
                    resp_t e;
                    e = q0.pop_front();
                    check("rdata0", rdata0, {32'd0, e.rdata});
                    check("ex0", ex0, e.ex);
                    check("exccode0", exc0, e.ex ? 6'h08 : 6'h00);
                    check("uncache0", unc0, e.unc);
                    check("count0", count0, 2'd1);
                    last0 = e;
                end
            end else begin
                check("hold_rdata0", rdata0, {32'd0, last0.rdata});
                check("hold_ex0", ex0, last0.ex);
                check("hold_unc0", unc0, last0.unc);
                check("idle_count0", count0, 2'd0);
            end
        end
    end

    task automatic drv0(input bit req, input logic [31:0] addr, input bit cancel);
        resp_t       e;
        logic [31:0] o;
        @(posedge clk);
        #1;
        req0    = req;
        addr0   = addr;
        cancel0 = cancel;
        if (cancel) q0.delete();
        e = exp_of(addr);
        o = addr - BASE;
        if (req) q0.push_back(e);
        @(negedge clk);
        check("addr_ok0", ok0, req);
        check("ram_en0", ram_en0, req && !e.ex);
        if (req && !e.ex) check("ram_addr0", ram_addr0, o[15:2]);
    endtask

    // ---------------- dut2 helpers ----------------
    int vcount2 = 0;
    always @(negedge clk) if (valid2) vcount2++;

    task automatic tick2(input bit req, input logic [31:0] addr);
        @(posedge clk);
        #1;
        req2  = req;
        addr2 = addr;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        // reset state
        repeat (2) @(negedge clk);
        check("rst_outs0", {ok0, valid0, rdata0, count0, ex0, exc0, unc0, ram_en0, ram_addr0}, '0);
        check("rst_outs2", {ok2, valid2, rdata2, count2, ex2, exc2, unc2, ram_en2, ram_addr2}, '0);
        @(posedge clk); #1;
        rst0 = 1'b1;
        rst2 = 1'b1;

        // pipelined back-to-back fetch
        drv0(1, BASE, 0);
        drv0(1, BASE + 32'd4, 0);
        drv0(1, BASE + 32'd8, 0);
        drv0(0, '0, 0);
        drv0(0, '0, 0);
        // misaligned -> ADEF, then hold
        drv0(1, BASE + 32'd2, 0);
        drv0(0, '0, 0);
        drv0(0, '0, 0);
        // window boundaries
        drv0(1, BASE + 32'h0000_FFFC, 0);
        drv0(1, BASE + 32'h0001_0000, 0);
        drv0(1, BASE - 32'd4, 0);
        drv0(0, '0, 0);
        // uncache window (outside RAM -> also ADEF)
        drv0(1, 32'h1f00_0000, 0);
        drv0(0, '0, 0);
        // cancel: A killed, B returned
        drv0(1, BASE + 32'h40, 0);
        drv0(1, BASE + 32'h80, 1);
        drv0(0, '0, 0);
        // cancel with nothing in flight
        drv0(0, '0, 1);
        drv0(0, '0, 0);
        // cancel in the response cycle with no new request
        drv0(1, BASE + 32'hC0, 0);
        drv0(0, '0, 1);
        drv0(0, '0, 0);
        // random traffic
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: a = BASE + 4 * $urandom_range(0, 16383);
                1: a = BASE + 4 * $urandom_range(0, 16383) + $urandom_range(1, 3);
                2: a = BASE + 32'h0001_0000 + 4 * $urandom_range(0, 255);
                3: a = 32'h1f00_0000 + 4 * $urandom_range(0, 255);
                default: a = $urandom;
            endcase
            drv0($urandom_range(0, 3) != 0, a, $urandom_range(0, 5) == 0);
        end
        drv0(0, '0, 0);
        drv0(0, '0, 0);
        check("sb_empty0", q0.size(), 0);

        // WAIT_CYC=2 timing: accept t0, ram_en t2, valid t3
        tick2(1, BASE + 32'h10);
        check("t0_ok2", ok2, 1);
        check("t0_en2", ram_en2, 0);
        tick2(1, BASE + 32'h10);
        check("t1_ok2", ok2, 0);
        check("t1_en2", ram_en2, 0);
        tick2(1, BASE + 32'h10);
        check("t2_ok2", ok2, 0);
        check("t2_en2", ram_en2, 1);
        check("t2_addr2", ram_addr2, 14'd4);
        tick2(1, BASE + 32'h10);
        check("t3_ok2", ok2, 0);
        check("t3_valid2", valid2, 1);
        check("t3_rdata2", rdata2, {32'd0, ram_fn(14'd4)});
        check("t3_count2", count2, 2'd1);
        tick2(0, '0);
        check("t4_valid2", valid2, 0);
        check("t4_hold2", rdata2, {32'd0, ram_fn(14'd4)});

        // uncache/ADEF response on the wait path, leaving nonzero held state
        tick2(1, 32'h1f00_0000);
        tick2(0, '0);
        check("unc_en2", ram_en2, 0);
        tick2(0, '0);
        check("unc_en2b", ram_en2, 0);
        tick2(0, '0);
        check("unc_valid2", valid2, 1);
        check("unc_attr2", {ex2, exc2, unc2, rdata2}, {1'b1, 6'h08, 1'b1, 64'd0});

        // async reset mid-WAIT
        tick2(1, BASE + 32'h20);
        tick2(0, '0);
        rst2 = 1'b0;
        #1;
        check("rst_mid2", {ok2, valid2, rdata2, count2, ex2, exc2, unc2, ram_en2, ram_addr2}, '0);
        @(posedge clk); #1;
        rst2 = 1'b1;
        vcount2 = 0;
        repeat (6) tick2(0, '0);
        check("no_valid_after_rst2", vcount2, 0);
        check("post_rst_outs2", {rdata2, ex2, exc2, unc2}, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
